// File: rtl/dac_spi_pkg.sv
// rtl/dac_spi_pkg.sv - frame layout, command codes and FSM encoding for the DAC SPI receiver
package dac_spi_pkg;

    localparam int FRAME_BITS = 32;
    localparam int DATA_W     = 12;
    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 6;

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam int CMD_LSB  = 20;
    localparam int ADDR_LSB = 16;
    localparam int DATA_LSB = 4;

    localparam logic [3:0] CMD_WR     = 4'b0000;
    localparam logic [3:0] CMD_UPD    = 4'b0001;
    localparam logic [3:0] CMD_WR_UPD = 4'b0011;
    localparam logic [3:0] CMD_PWDN   = 4'b0100;
    localparam logic [3:0] CMD_NOP    = 4'b1111;
    localparam logic [3:0] ADDR_ALL   = 4'hF;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [3:0]        addr;
        logic [DATA_W-1:0] data;
    } frame_t;

    function automatic frame_t decode_frame(input logic [FRAME_BITS-1:0] sr);
        frame_t f;
        f.cmd  = sr[CMD_LSB +: 4];
        f.addr = sr[ADDR_LSB +: 4];
        f.data = sr[DATA_LSB +: DATA_W];
        return f;
    endfunction

    function automatic logic ch_sel(input logic [3:0] addr, input int ch);
        return (addr == ADDR_ALL) || (addr == 4'(ch));
    endfunction

endpackage

// File: rtl/dac_spi_receiver_sync_edge_det.sv
// rtl/dac_spi_receiver_sync_edge_det.sv - two-flop synchroniser with rise/fall pulses
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/dac_spi_receiver.sv
// rtl/dac_spi_receiver.sv - LTC2624-style SPI slave model; DAC_RX_ERR_CNT_EN adds err_cnt_o
module dac_spi_receiver
    import dac_spi_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     spi_sck_i,
    input  logic                     spi_mosi_i,
    input  logic                     dac_cs_i,
    input  logic                     dac_clr_i,
    output logic                     frame_vld_o,
    output logic                     frame_err_o,
    output logic [3:0]               cmd_o,
    output logic [3:0]               addr_o,
    output logic [DATA_W-1:0]        data_o,
    output logic [NUM_CH*DATA_W-1:0] dac_out_o,
`ifdef DAC_RX_ERR_CNT_EN
    output logic [7:0]               err_cnt_o,
`endif
    output logic [NUM_CH-1:0]        pwr_dn_o
);

    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic cs_lvl, cs_rise, cs_fall;

    sync_edge_det u_sck  (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi_sck_i),
                          .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall));
    sync_edge_det u_mosi (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi_mosi_i),
                          .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));
    sync_edge_det u_cs   (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(dac_cs_i),
                          .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));

    logic unused_sync;
    assign unused_sync = sck_lvl ^ sck_fall ^ mosi_rise ^ mosi_fall ^ cs_lvl;

    // Clear only needs a level, so a plain two-flop chain is enough.
    logic [1:0] clr_sync_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clr_sync_q <= 2'b00;
        end else begin
            clr_sync_q <= {clr_sync_q[0], dac_clr_i};
        end
    end
    logic clr_active;
    assign clr_active = ~clr_sync_q[1];

    logic [1:0]            state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (sck_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], mosi_lvl};
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (cs_rise) begin
                    state_d = ST_DECODE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic   frame_ok, frame_bad;
    frame_t frame;
    assign frame_ok  = (state_q == ST_DECODE) && (cnt_q == FRAME_CNT);
    assign frame_bad = (state_q == ST_DECODE) && (cnt_q != FRAME_CNT);
    assign frame     = decode_frame(shift_q);

    logic [NUM_CH-1:0][DATA_W-1:0] inp_q, inp_d, dac_q, dac_d;
    logic [NUM_CH-1:0]             pd_q, pd_d;

    always_comb begin
        inp_d = inp_q;
        dac_d = dac_q;
        pd_d  = pd_q;
        if (frame_ok) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (ch_sel(frame.addr, ch)) begin
                    case (frame.cmd)
                        CMD_WR: begin
                            inp_d[ch] = frame.data;
                            pd_d[ch]  = 1'b0;
                        end
                        CMD_UPD: begin
                            dac_d[ch] = inp_q[ch];
                            pd_d[ch]  = 1'b0;
                        end
                        CMD_WR_UPD: begin
                            inp_d[ch] = frame.data;
                            dac_d[ch] = frame.data;
                            pd_d[ch]  = 1'b0;
                        end
                        CMD_PWDN: pd_d[ch] = 1'b1;
                        default:  ;
                    endcase
                end
            end
        end
        // Clear wins over any write decoded in the same cycle.
        if (clr_active) begin
            inp_d = '0;
            dac_d = '0;
            pd_d  = '0;
        end
    end

    logic [3:0]        cmd_q, addr_q;
    logic [DATA_W-1:0] data_q;
    logic              vld_q, err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            inp_q   <= '0;
            dac_q   <= '0;
            pd_q    <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            inp_q   <= inp_d;
            dac_q   <= dac_d;
            pd_q    <= pd_d;
            vld_q   <= frame_ok;
            err_q   <= frame_bad;
            if (frame_ok) begin
                cmd_q  <= frame.cmd;
                addr_q <= frame.addr;
                data_q <= frame.data;
            end
        end
    end

`ifdef DAC_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= 8'd0;
        end else if (frame_bad && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
    assign err_cnt_o = err_cnt_q;
`endif

    assign frame_vld_o = vld_q;
    assign frame_err_o = err_q;
    assign cmd_o       = cmd_q;
    assign addr_o      = addr_q;
    assign data_o      = data_q;
    assign dac_out_o   = dac_q;
    assign pwr_dn_o    = pd_q;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// tb/tb_dac_spi_receiver.sv - randomized self-checking bench for dac_spi_receiver
module tb_dac_spi_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck, mosi, cs, clr;
    logic        frame_vld, frame_err;
    logic [3:0]  cmd, addr;
    logic [11:0] data;
    logic [47:0] dac_out;
    logic [3:0]  pwr_dn;
`ifdef DAC_RX_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    dac_spi_receiver dut (
        .clk_i(clk), .rst_ni(rst_n), .spi_sck_i(sck), .spi_mosi_i(mosi),
        .dac_cs_i(cs), .dac_clr_i(clr), .frame_vld_o(frame_vld),
        .frame_err_o(frame_err), .cmd_o(cmd), .addr_o(addr), .data_o(data),
        .dac_out_o(dac_out),
`ifdef DAC_RX_ERR_CNT_EN
        .err_cnt_o(err_cnt),
`endif
        .pwr_dn_o(pwr_dn)
    );

    int n_checks = 0;
    int n_errors = 0;
    int vld_seen = 0;
    int err_seen = 0;
    int vld_exp  = 0;
    int err_exp  = 0;

    always @(negedge clk) begin
        if (frame_vld) vld_seen++;
        if (frame_err) err_seen++;
    end

    // Reference model of the DAC register file
    logic [11:0] m_inp [4];
    logic [11:0] m_dac [4];
    logic [3:0]  m_pd;
    logic [3:0]  m_cmd, m_addr;
    logic [11:0] m_data;
    int          m_errcnt;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_inp[i] = '0;
            m_dac[i] = '0;
        end
        m_pd = '0; m_cmd = '0; m_addr = '0; m_data = '0; m_errcnt = 0;
    endtask

    task automatic model_frame(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
        m_cmd = c; m_addr = a; m_data = d;
        vld_exp++;
        for (int ch = 0; ch < 4; ch++) begin
            if (a == 4'hF || int'(a) == ch) begin
                if (c == 4'b0000) begin
                    m_inp[ch] = d; m_pd[ch] = 1'b0;
                end else if (c == 4'b0001) begin
                    m_dac[ch] = m_inp[ch]; m_pd[ch] = 1'b0;
                end else if (c == 4'b0011) begin
                    m_inp[ch] = d; m_dac[ch] = d; m_pd[ch] = 1'b0;
                end else if (c == 4'b0100) begin
                    m_pd[ch] = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dac"}, 64'(dac_out), 64'({m_dac[3], m_dac[2], m_dac[1], m_dac[0]}));
        check({tag, ".pwr_dn"}, 64'(pwr_dn), 64'(m_pd));
        check({tag, ".fields"}, 64'({cmd, addr, data}), 64'({m_cmd, m_addr, m_data}));
        check({tag, ".vld_cnt"}, 64'(vld_seen), 64'(vld_exp));
        check({tag, ".err_cnt_pulses"}, 64'(err_seen), 64'(err_exp));
`ifdef DAC_RX_ERR_CNT_EN
        check({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_errcnt));
`endif
    endtask

    task automatic shift_bits(input int nbits, input logic [63:0] word);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = word[i];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic send(input int nbits, input logic [63:0] word);
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(nbits, word);
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    function automatic logic [63:0] mk(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
        logic [7:0] hi;
        logic [3:0] lo;
        hi = 8'($urandom);
        lo = 4'($urandom);
        return {32'd0, hi, c, a, d, lo};
    endfunction

    task automatic good(input string tag, input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
        send(32, mk(c, a, d));
        model_frame(c, a, d);
        check_all(tag);
    endtask

    task automatic bad(input string tag, input int nbits);
        logic [63:0] w;
        w = {$urandom, $urandom};
        send(nbits, w);
        err_exp++;
        if (m_errcnt < 255) m_errcnt++;
        check_all(tag);
    endtask

    task automatic pulse_clr(input string tag);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            m_inp[i] = '0;
            m_dac[i] = '0;
        end
        m_pd = '0;
        check_all(tag);
    endtask

    logic [3:0] cmd_tab [6];
    logic [3:0] addr_tab [6];

    initial begin
        cmd_tab  = '{4'h0, 4'h1, 4'h3, 4'h4, 4'hF, 4'h7};
        addr_tab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF, 4'h9};
        rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; cs = 1'b1; clr = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        check("reset.pulses", 64'({frame_vld, frame_err}), 64'd0);
        check_all("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        good("t1", 4'b0011, 4'h0, 12'hABC);
        good("t2a", 4'b0000, 4'h2, 12'h123);
        good("t2b", 4'b0001, 4'h2, 12'h000);
        good("t3", 4'b0011, 4'hF, 12'h7FF);
        pulse_clr("t3clr");
        bad("t4a", 31);
        bad("t4b", 33);
        good("t5a", 4'b0100, 4'h1, 12'h000);
        good("t5b", 4'b0011, 4'h1, 12'h001);
        good("oob_addr", 4'b0011, 4'h5, 12'h555);

        // Reset in the middle of a frame, released while cs is still low
        begin
            logic [63:0] w;
            w = mk(4'b0011, 4'h3, 12'hFED);
            @(negedge clk);
            cs = 1'b0;
            repeat (4) @(negedge clk);
            shift_bits(16, w >> 16);
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            model_reset();
            shift_bits(16, w);
            repeat (4) @(negedge clk);
            cs = 1'b1;
            repeat (10) @(negedge clk);
            check_all("t6_abort");
        end
        good("t6_next", 4'b0011, 4'h3, 12'hFED);

        for (int it = 0; it < 40; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                bad("rnd_bad", (($urandom & 1) != 0) ? int'($urandom_range(28, 31)) : int'($urandom_range(33, 36)));
            end else if (r == 1) begin
                pulse_clr("rnd_clr");
            end else begin
                logic [3:0] c, a;
                c = cmd_tab[$urandom_range(0, 5)];
                a = addr_tab[$urandom_range(0, 5)];
                if (c == 4'h7) c = 4'($urandom);
                if (a == 4'h9) a = 4'($urandom);
                good("rnd", c, a, 12'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
